data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder end of the data-memory request interface driven by the processor's memory stage.
- Accepts one read or write request at a time through a valid/ready handshake.
- Performs the access after a fixed number of cycles, then holds a response until the requester acknowledges it.
- Sits between the memory-stage initiator and the word-addressed data RAM, so that slow or multi-cycle memory can be modelled without changing the pipeline.

Parameters:
- DATA_WIDTH, 22, data word width
- ADDR_WIDTH, 22, request address width (word address)
- DEPTH, 256, number of implemented words; valid addresses are 0 to DEPTH-1
- LATENCY, 2, cycles from request acceptance to response; legal range is 1 to 15

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_WIDTH  word address
- req_wdata  input  DATA_WIDTH  write data
- resp_valid  output  1  response present
- resp_ready  input  1  requester accepts the response
- resp_rdata  output  DATA_WIDTH  read data; 0 for writes and for errors
- resp_err  output  1  address was out of range
- busy  output  1  a request is in flight (state is not IDLE)

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE and the latency counter clears to 0.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
  - The memory array is not cleared; its contents are retained.
  - A pending access interrupted by reset is discarded; a write that has not yet committed never reaches the array.
- States: IDLE, WAIT, RESP.
- req_ready = (state==IDLE), combinational from state only. busy = (state!=IDLE).
- IDLE:
  - Acceptance occurs at a rising edge where req_valid && req_ready.
  - On acceptance, latch req_write, req_addr and req_wdata into internal registers, load the counter with LATENCY-1, and go to WAIT.
  - Request inputs are don't-care after the accepting edge.
- WAIT:
  - If counter != 0, decrement the counter.
  - If counter == 0, commit the access at this edge and go to RESP.
  - New requests are ignored because req_ready=0.
- Commit, using the latched values:
  - In range (addr < DEPTH), write: mem[addr] <= wdata; resp_rdata <= 0; resp_err <= 0.
  - In range, read: resp_rdata <= mem[addr]; resp_err <= 0.
  - Out of range: no array write; resp_rdata <= 0; resp_err <= 1.
  - resp_valid <= 1.
- Timing: a request accepted at edge T has resp_valid high in the cycle after edge T+LATENCY.
- RESP:
  - resp_valid, resp_rdata and resp_err hold stable until an edge with resp_ready=1.
  - At that edge: resp_valid <= 0, resp_rdata <= 0, resp_err <= 0, go to IDLE.
  - With resp_ready held at 1, the earliest next acceptance is one edge after response retirement. Peak throughput is therefore one request per LATENCY+2 cycles.
- Read-after-write to the same address returns the newly written data, because the write commits before the read is accepted.
- Address comparison uses the full ADDR_WIDTH bits; there is no wrap or aliasing of high bits.
- resp_ready asserted while resp_valid=0 has no effect.

Test Plan:
- Reset then idle: assert rst mid-cycle (async) -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0 immediately, without waiting for a clock edge.
- Write then read, LATENCY=2, resp_ready tied to 1:
  - Write addr 0x00005, data 0x3ABCDE accepted at edge T -> resp_valid high after edge T+2, resp_rdata=0, resp_err=0.
  - Read addr 5 -> resp_rdata=0x3ABCDE.
- Backpressure:
  - Read with resp_ready=0 for 4 cycles -> resp_valid and resp_rdata stay stable and req_ready=0 throughout.
  - Raise resp_ready -> resp_valid drops next edge and req_ready=1.
- Out of range, DEPTH=256:
  - Write addr 0x000100, data 0x111111 -> resp_err=1, resp_rdata=0.
  - Read addr 0x000000 -> prior contents unchanged (no aliasing).
- Reset mid-operation: write addr 7, data 0x2AAAAA accepted, then rst pulsed during WAIT -> resp_valid never asserts; a subsequent read of addr 7 returns its pre-write value.
- Latency sweep:
  - LATENCY=1 -> response appears after edge T+1.
  - LATENCY=15 -> response appears after edge T+15.
  - For both, a request presented in WAIT or RESP is not accepted (req_ready=0).

Source files
------------

// File: rtl/data_memory_responder.sv
// data_memory_responder: valid/ready responder in front of a word-addressed data RAM.
// Each accepted request is committed LATENCY cycles later and its response is held until taken.
module data_memory_responder #(
    parameter int DATA_WIDTH = 22,
    parameter int ADDR_WIDTH = 22,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy
);
    localparam int                  IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [3:0]          CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [3:0]              cnt_r;
    logic                    wr_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    logic                    accept_s;
    logic                    commit_s;
    logic                    retire_s;
    logic                    in_range_s;
    logic [IDX_W-1:0]        idx_s;
    logic [DATA_WIDTH-1:0]   rd_word_s;

    assign accept_s   = (state_r == ST_IDLE) && req_valid;
    assign commit_s   = (state_r == ST_WAIT) && (cnt_r == 4'd0);
    assign retire_s   = (state_r == ST_RESP) && resp_ready;
    // Full-width compare: high address bits never alias into the array.
    assign in_range_s = ({1'b0, addr_r} < DEPTH_L);
    assign idx_s      = addr_r[IDX_W-1:0];
    assign rd_word_s  = mem_r[idx_s];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) state_nxt_s = ST_WAIT;
                else           state_nxt_s = ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) state_nxt_s = ST_RESP;
                else               state_nxt_s = ST_WAIT;
            end
            ST_RESP: begin
                if (resp_ready) state_nxt_s = ST_IDLE;
                else            state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Handshake/status decode from state only
    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b1;
        case (state_r)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            ST_WAIT, ST_RESP: begin
                req_ready = 1'b0;
                busy      = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
                busy      = 1'b1;
            end
        endcase
    end

    // Request capture and latency countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= 4'd0;
            wr_r    <= 1'b0;
            addr_r  <= {ADDR_WIDTH{1'b0}};
            wdata_r <= {DATA_WIDTH{1'b0}};
        end else if (accept_s) begin
            cnt_r   <= CNT_LOAD;
            wr_r    <= req_write;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
        end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Response registers: loaded at commit, cleared when the requester takes them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= {DATA_WIDTH{1'b0}};
            resp_err   <= 1'b0;
        end else if (commit_s) begin
            resp_valid <= 1'b1;
            if (!in_range_s) begin
                resp_rdata <= {DATA_WIDTH{1'b0}};
                resp_err   <= 1'b1;
            end else if (wr_r) begin
                resp_rdata <= {DATA_WIDTH{1'b0}};
                resp_err   <= 1'b0;
            end else begin
                resp_rdata <= rd_word_s;
                resp_err   <= 1'b0;
            end
        end else if (retire_s) begin
            resp_valid <= 1'b0;
            resp_rdata <= {DATA_WIDTH{1'b0}};
            resp_err   <= 1'b0;
        end
    end

    // Data array: not reset, so contents survive rst; only a committed in-range write updates it
    always_ff @(posedge clk) begin
        if (commit_s && wr_r && in_range_s) begin
            mem_r[idx_s] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: three instances (LATENCY 2, 1, 15) checked every cycle
// against a transaction-timing model, plus directed literal checks on the LATENCY=2 lane.
module tb_data_memory_responder;
    localparam int DW    = 22;
    localparam int AW    = 22;
    localparam int DEPTH = 256;
    localparam int NL    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NL-1:0] rst, req_valid, req_write, resp_ready;
    logic [AW-1:0] req_addr  [NL];
    logic [DW-1:0] req_wdata [NL];
    logic [NL-1:0] req_ready, resp_valid, resp_err, busy;
    logic [DW-1:0] resp_rdata [NL];

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit running  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    for (genvar g = 0; g < NL; g++) begin : lane
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

        data_memory_responder #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(LAT)
        ) dut (
            .clk(clk), .rst(rst[g]),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_write(req_write[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
            .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g]), .busy(busy[g])
        );

        // Model: a request taken at edge T is due at edge T+LAT; a held response leaves on resp_ready.
        logic [DW-1:0] m_mem   [DEPTH];
        bit            m_known [DEPTH];
        longint        edge_no = 0;
        longint        due     = 0;
        bit            pend = 1'b0, held = 1'b0, was_free;
        bit            p_wr;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wdata;
        logic [DW-1:0] e_rdata = '0;
        bit            e_err = 1'b0, e_known = 1'b1;

        always @(posedge clk or posedge rst[g]) begin
            if (rst[g]) begin
                pend = 1'b0; held = 1'b0; e_rdata = '0; e_err = 1'b0; e_known = 1'b1;
            end else begin
                was_free = !pend && !held;
                edge_no++;
                if (held && resp_ready[g]) begin
                    held = 1'b0; e_rdata = '0; e_err = 1'b0; e_known = 1'b1;
                end
                if (pend && edge_no == due) begin
                    pend = 1'b0; held = 1'b1;
                    if (p_addr >= DEPTH) begin
                        e_err = 1'b1; e_rdata = '0; e_known = 1'b1;
                    end else if (p_wr) begin
                        m_mem[p_addr[7:0]] = p_wdata; m_known[p_addr[7:0]] = 1'b1;
                        e_err = 1'b0; e_rdata = '0; e_known = 1'b1;
                    end else begin
                        e_err = 1'b0; e_rdata = m_mem[p_addr[7:0]]; e_known = m_known[p_addr[7:0]];
                    end
                end
                if (was_free && req_valid[g]) begin
                    pend = 1'b1; due = edge_no + LAT;
                    p_wr = req_write[g]; p_addr = req_addr[g]; p_wdata = req_wdata[g];
                end
            end
        end

        always @(negedge clk) begin
            if (running && !rst[g]) begin
                check($sformatf("lane%0d rdy/busy/vld/err", g),
                      {req_ready[g], busy[g], resp_valid[g], resp_err[g]},
                      {!pend && !held, pend || held, held, e_err});
                if (e_known) check($sformatf("lane%0d rdata", g), resp_rdata[g], e_rdata);
            end
        end
    end

    task automatic send0(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int lat, output logic [DW-1:0] rd, output logic er);
        int k;
        k = 0;
        while (!req_ready[0] && k < 100) begin @(posedge clk); #1; k++; end
        check("lane0 ready wait", 64'(k < 100), 64'd1);
        req_valid[0] = 1'b1; req_write[0] = w; req_addr[0] = a; req_wdata[0] = d;
        @(posedge clk); #1;
        req_valid[0] = 1'b0; req_addr[0] = 22'($urandom); req_wdata[0] = 22'($urandom);
        lat = 0;
        while (!resp_valid[0] && lat < 40) begin @(posedge clk); #1; lat++; end
        rd = resp_rdata[0];
        er = resp_err[0];
    endtask

    initial begin
        int            lat;
        logic [DW-1:0] rd;
        logic          er;
        int            sel;

        rst = '1; req_valid = '0; req_write = '0; resp_ready = '1;
        for (int l = 0; l < NL; l++) begin req_addr[l] = '0; req_wdata[l] = '0; end
        repeat (3) @(posedge clk);
        #2 rst = '0;
        running = 1'b1;
        @(posedge clk); #1;

        // Write then read with resp_ready tied high
        send0(1'b1, 22'h000005, 22'h3ABCDE, lat, rd, er);
        check("wr5 latency", 64'(lat), 64'd2);
        check("wr5 rdata", rd, 64'd0);
        check("wr5 err", er, 64'd0);
        send0(1'b0, 22'h000005, 22'h000000, lat, rd, er);
        check("rd5 rdata", rd, 64'h3ABCDE);
        check("rd5 latency", 64'(lat), 64'd2);

        // Out of range must not alias onto address 0
        send0(1'b1, 22'h000000, 22'h155555, lat, rd, er);
        send0(1'b1, 22'h000100, 22'h111111, lat, rd, er);
        check("oor err", er, 64'd1);
        check("oor rdata", rd, 64'd0);
        send0(1'b0, 22'h000000, 22'h000000, lat, rd, er);
        check("rd0 after oor", rd, 64'h155555);

        // Reset during WAIT discards a pending write
        send0(1'b1, 22'h000007, 22'h012345, lat, rd, er);
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 22'h000007; req_wdata[0] = 22'h2AAAAA;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("busy after accept", busy[0], 64'd1);
        #2 rst[0] = 1'b1;
        #1;
        check("async rst outputs", {req_ready[0], resp_valid[0], resp_err[0], busy[0]}, 64'b1000);
        check("async rst rdata", resp_rdata[0], 64'd0);
        repeat (2) @(posedge clk);
        #2 rst[0] = 1'b0;
        send0(1'b0, 22'h000007, 22'h000000, lat, rd, er);
        check("rd7 after aborted wr", rd, 64'h012345);

        // Backpressure: response held while resp_ready is low, stray requests ignored
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        send0(1'b0, 22'h000005, 22'h000000, lat, rd, er);
        for (int i = 0; i < 4; i++) begin
            req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 22'h000005; req_wdata[0] = 22'h0000AA;
            check("bp hold", {resp_valid[0], req_ready[0]}, 64'b10);
            check("bp rdata", resp_rdata[0], 64'h3ABCDE);
            @(posedge clk); #1;
        end
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("bp release", {resp_valid[0], req_ready[0]}, 64'b01);
        send0(1'b0, 22'h000005, 22'h000000, lat, rd, er);
        check("rd5 after ignored wr", rd, 64'h3ABCDE);

        // Random traffic on all lanes, with occasional asynchronous resets
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            for (int l = 0; l < NL; l++) begin
                if (rst[l]) rst[l] = 1'b0;
                else if ($urandom_range(0, 249) == 0) rst[l] = 1'b1;
                req_valid[l]  = 1'($urandom_range(0, 1));
                req_write[l]  = 1'($urandom_range(0, 1));
                req_wdata[l]  = 22'($urandom);
                resp_ready[l] = ($urandom_range(0, 2) != 0);
                sel = $urandom_range(0, 9);
                if (sel == 0)      req_addr[l] = 22'($urandom);
                else if (sel == 1) req_addr[l] = ($urandom_range(0, 1) != 0) ? 22'd255 : 22'd256;
                else               req_addr[l] = 22'($urandom_range(0, 15));
            end
        end
        @(posedge clk); #1;
        rst = '0; req_valid = '0;
        repeat (20) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
